// File: rtl/prog_mem_pkg.sv
// rtl/prog_mem_pkg.sv - shared encodings and image lengths for prog_mem
package prog_mem_pkg;

  typedef enum logic [1:0] {
    PROG_SIMPLE = 2'd0,
    PROG_IO     = 2'd1,
    PROG_SIGMA  = 2'd2,
    PROG_BLANK  = 2'd3
  } prog_sel_t;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int LEN_SIMPLE = 8;
  localparam int LEN_IO     = 4;
  localparam int LEN_SIGMA  = 12;

endpackage

// File: rtl/prog_mem_if.sv
// rtl/prog_mem_if.sv - CPU-side bus and boot controls of prog_mem
interface prog_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADRS_W = 8
);
  import prog_mem_pkg::*;

  prog_sel_t           prog_sel;
  logic                reload;
  logic [ADRS_W-1:0]   adrs;
  logic [DATA_W-1:0]   data;
  logic                wr_en;
  logic [DATA_W-1:0]   q;
  logic                ready;

  modport master (
    output prog_sel, reload, adrs, data, wr_en,
    input  q, ready
  );

  modport slave (
    input  prog_sel, reload, adrs, data, wr_en,
    output q, ready
  );

endinterface

// File: rtl/prog_image_rom.sv
// rtl/prog_image_rom.sv - built-in boot images; addresses past an image read zero
module prog_image_rom
  import prog_mem_pkg::*;
#(
  parameter int AD_W = 9
) (
  input  prog_sel_t         i_sel,
  input  logic [AD_W-1:0]   i_ad,
  output logic [7:0]        o_byte
);

  logic [31:0] w_idx;
  assign w_idx = 32'(i_ad);

  always_comb begin
    o_byte = 8'h00;
    case (i_sel)
      PROG_SIMPLE: begin
        case (w_idx)
          32'd0:   o_byte = 8'h81;
          32'd1:   o_byte = 8'h07;
          32'd2:   o_byte = 8'h06;
          32'd3:   o_byte = 8'h22;
          32'd4:   o_byte = 8'h41;
          32'd5:   o_byte = 8'hc0;
          32'd6:   o_byte = 8'h05;
          32'd7:   o_byte = 8'h03;
          default: o_byte = 8'h00;
        endcase
      end
      PROG_IO: begin
        case (w_idx)
          32'd0:   o_byte = 8'h01;
          32'd1:   o_byte = 8'h04;
          32'd2:   o_byte = 8'hc0;
          default: o_byte = 8'h00;
        endcase
      end
      PROG_SIGMA: begin
        case (w_idx)
          32'd0:   o_byte = 8'h01;
          32'd1:   o_byte = 8'h06;
          32'd2:   o_byte = 8'h46;
          32'd3:   o_byte = 8'hda;
          32'd4:   o_byte = 8'h09;
          32'd5:   o_byte = 8'h22;
          32'd6:   o_byte = 8'h46;
          32'd7:   o_byte = 8'hc0;
          32'd8:   o_byte = 8'h03;
          32'd9:   o_byte = 8'h04;
          32'd10:  o_byte = 8'hc0;
          default: o_byte = 8'h00;
        endcase
      end
      default: o_byte = 8'h00;
    endcase
  end

endmodule

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - writable program RAM booted from a built-in image
// Optional PROG_MEM_CHECKSUM_EN adds an 8-bit boot checksum output.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADRS_W = 8,
  parameter int DEPTH  = 2**ADRS_W
) (
  input  logic       clock,
  input  logic       reset,
  prog_mem_if.slave  bus
`ifdef PROG_MEM_CHECKSUM_EN
  ,
  output logic [7:0] checksum
`endif
);

  localparam logic [ADRS_W:0] LAST_AD  = (ADRS_W+1)'(DEPTH-1);
  localparam logic [ADRS_W:0] DEPTH_AD = (ADRS_W+1)'(DEPTH);

  state_t              r_state;
  logic [ADRS_W:0]     r_cnt;
  prog_sel_t           r_sel;
  logic [DATA_W-1:0]   r_q;
  logic                r_ready;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic [7:0]          w_byte;
  logic                w_in_range;
  logic                w_boot_we;
  logic                w_run_we;
  logic [ADRS_W-1:0]   w_wa;
  logic [DATA_W-1:0]   w_wd;

  prog_image_rom #(.AD_W(ADRS_W+1)) u_rom (
    .i_sel  (r_sel),
    .i_ad   (r_cnt),
    .o_byte (w_byte)
  );

  assign w_in_range = ({1'b0, bus.adrs} < DEPTH_AD);
  // reload takes priority over both the boot copy and a CPU write
  assign w_boot_we  = !reset && (r_state == ST_BOOT) && !bus.reload;
  assign w_run_we   = !reset && (r_state == ST_RUN) && !bus.reload && bus.wr_en && w_in_range;
  assign w_wa       = w_boot_we ? r_cnt[ADRS_W-1:0] : bus.adrs;
  assign w_wd       = w_boot_we ? DATA_W'(w_byte) : bus.data;

  always_ff @(posedge clock) begin
    if (w_boot_we || w_run_we) begin
      r_mem[w_wa] <= w_wd;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_cnt   <= '0;
      r_q     <= '0;
      r_ready <= 1'b0;
      r_sel   <= bus.prog_sel;
    end else if (bus.reload) begin
      r_state <= ST_BOOT;
      r_cnt   <= '0;
      r_q     <= '0;
      r_ready <= 1'b0;
      r_sel   <= bus.prog_sel;
    end else begin
      case (r_state)
        ST_BOOT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_AD) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          // the read address is always the write address, so write-first means forwarding data
          if (bus.wr_en && w_in_range) begin
            r_q <= bus.data;
          end else if (w_in_range) begin
            r_q <= r_mem[bus.adrs];
          end else begin
            r_q <= '0;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

  assign bus.q     = r_q;
  assign bus.ready = r_ready;

`ifdef PROG_MEM_CHECKSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_csum <= 8'h00;
    end else if (bus.reload) begin
      r_csum <= 8'h00;
    end else if (r_state == ST_BOOT) begin
      r_csum <= r_csum + w_byte;
    end
  end

  assign checksum = r_csum;
`endif

endmodule

// File: doc/prog_mem.md
Name: prog_mem

Overview:
Parametrised, writable program memory for the CDEC CPU. It replaces the fixed combinational program table.
- After reset or a reload request, a boot FSM copies one of several built-in program images into internal RAM.
- After the copy it serves registered reads and run-time writes to the CPU.
- Sits between the CPU fetch/data bus and the DE0 board switches. The switches select the program to boot.

Parameters:
DATA_W, 8, memory word width; images are zero-extended when DATA_W > 8
ADRS_W, 8, address width; must be >= 4
DEPTH, 2**ADRS_W, number of words; must be <= 2**ADRS_W

Ports:
clock  in  1  system clock; all state changes on rising edge
reset  in  1  asynchronous, active-high reset
prog_sel  in  2  image select, sampled at boot start: 0 simple, 1 io, 2 sigma, 3 blank (all zero)
reload  in  1  single-cycle request to re-run boot
adrs  in  ADRS_W  CPU read/write address
data  in  DATA_W  CPU write data
wr_en  in  1  CPU write strobe
q  out  DATA_W  registered read data
ready  out  1  high when memory is in RUN and CPU may fetch

Behaviour:
- Reset (asynchronous, active-high): state=BOOT, boot counter cnt=0, q=0, ready=0, prog_sel captured into sel_r.
- BOOT state, each cycle:
  - mem[cnt] <= image(sel_r, cnt); cnt <= cnt+1.
  - When cnt==DEPTH-1 the write completes, state <= RUN and ready <= 1.
  - First ready=1 edge is exactly DEPTH cycles after reset deassertion.
- During BOOT: wr_en, adrs and data are ignored; q holds 0.
- RUN state:
  - Read latency is 1 cycle: q <= mem[adrs] on every edge.
  - wr_en=1: mem[adrs] <= data.
  - Same-address read-during-write is write-first: q shows the new data next cycle.
- reload=1 in RUN: next edge state=BOOT, cnt=0, ready=0, q=0, prog_sel resampled into sel_r.
- reload=1 during BOOT: cnt restarts at 0, prog_sel resampled, ready stays 0.
- reload and wr_en together in RUN: reload wins; the write is dropped.
- Reset mid-BOOT or mid-RUN: full restart as above. Partially copied contents are overwritten by the new boot.
- Image contents (byte addresses; all other addresses read 0):
  - simple: 81 07 06 22 41 c0 05 03
  - io: 01 04 c0 00
  - sigma: 01 06 46 da 09 22 46 c0 03 04 c0 00
  - If DEPTH < image length, the image is truncated to DEPTH words.
- cnt is ADRS_W+1 bits wide so it never wraps when DEPTH == 2**ADRS_W.

Optional Feature:
Macro PROG_MEM_CHECKSUM_EN.
- Defined:
  - Extra port: checksum out 8, running sum mod 256 of the low 8 bits of every word written during BOOT.
  - Cleared to 0 on reset and at every BOOT entry.
  - Frozen in RUN; run-time writes do not change it.
  - Valid when ready=1.
- Undefined: the port and adder are absent. All other behaviour is identical.

Decomposition:
- Package prog_mem_pkg holds:
  - prog_sel encodings (PROG_SIMPLE=0, PROG_IO=1, PROG_SIGMA=2, PROG_BLANK=3)
  - FSM state encoding (ST_BOOT, ST_RUN)
  - image length constants
- One combinational sub-module, prog_image_rom(sel, ad) -> 8-bit byte. It holds the three image tables.
- prog_mem holds the FSM, counter, RAM array and read register.

Test Plan:
- Boot sigma: reset, prog_sel=2, DEPTH=256 → ready rises 256 cycles after reset release. Then reads return: adrs 03 → q=da one cycle later; adrs 0b → 00; adrs 20 → 00. Checksum=1f if enabled.
- Boot simple then run-time write: prog_sel=0 → adrs 00 reads 81 and checksum=b9. Write wr_en adrs 07 data 55 → read adrs 07 gives 55. Same-cycle read/write to adrs 07 data 66 → q=66 next cycle.
- Reload to io: in RUN set prog_sel=1 and pulse reload → ready=0 next cycle; after 256 cycles ready=1. adrs 01 → 04; adrs 07 → 00 (earlier write gone). Checksum=c5.
- Writes ignored in BOOT: drive wr_en=1 adrs 05 data aa during boot with prog_sel=2 → after ready, adrs 05 reads 22.
- Reset mid-boot: assert reset at cnt=100, release → q=0 and ready=0 immediately; ready rises a full 256 cycles after release.
- Small config: ADRS_W=4 DEPTH=10 with sigma → ready after 10 cycles; adrs 09 → 04; adrs 0a/0b → 00 (truncated).
